tick_timer: RTL and testbench

TICK_TIMER -- requirements
Module: tick_timer

---
 rtl/tick_timer.sv | 124 ++++++++++++
 tb/tb_tick_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// Event counter with wrap/saturate option, free-running tick prescaler and a
// retriggerable tick-based timeout (IDLE/RUN/DONE) for the game FSM.
module tick_timer #(
  parameter int unsigned WIDTH         = 12,
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned TICK_HZ       = 2000,
  parameter int unsigned TIMEOUT_TICKS = 4000,
  parameter bit          SATURATE      = 1'b0
) (
  input  logic             clk_50M,
  input  logic             i_Zero,
  input  logic             i_Clear,
  input  logic             i_Enable,
  input  logic             i_TwoSec,
  input  logic             i_Abort,
  output logic [WIDTH-1:0] o_Count,
  output logic             o_Wrap,
  output logic             o_Tick,
  output logic             o_Busy,
  output logic             o_TwoSec
);

  localparam int unsigned     DIV        = CLK_HZ / TICK_HZ;
  localparam int unsigned     PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam logic [15:0]     TICK_LAST  = 16'(TIMEOUT_TICKS - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH-1:0] CNT_PENULT = CNT_MAX - WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic [15:0]      ticks, ticks_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic             wrap, wrap_nxt;
  logic             tick;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk_50M or posedge i_Zero) begin
    if (i_Zero) begin
      state <= IDLE;
      presc <= '0;
      ticks <= '0;
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      ticks <= ticks_nxt;
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

  // Start and retrigger both realign the prescaler so a full timeout follows.
  always_comb begin
    state_nxt = state;
    ticks_nxt = ticks;
    presc_nxt = tick ? '0 : presc + PW'(1);
    case (state)
      IDLE: begin
        if (i_TwoSec && !i_Abort) begin
          state_nxt = RUN;
          presc_nxt = '0;
          ticks_nxt = '0;
        end
      end
      RUN: begin
        if (i_Abort) begin
          state_nxt = IDLE;
          ticks_nxt = '0;
        end else if (i_TwoSec) begin
          presc_nxt = '0;
          ticks_nxt = '0;
        end else if (tick) begin
          if (ticks == TICK_LAST) begin
            state_nxt = DONE;
            ticks_nxt = '0;
          end else begin
            ticks_nxt = ticks + 16'd1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        ticks_nxt = '0;
      end
    endcase
  end

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (i_Clear) begin
      count_nxt = '0;
    end else if (i_Enable) begin
      if (SATURATE) begin
        if (count != CNT_MAX) begin
          count_nxt = count + WIDTH'(1);
          wrap_nxt  = (count == CNT_PENULT);
        end
      end else begin
        count_nxt = count + WIDTH'(1);
        wrap_nxt  = (count == CNT_MAX);
      end
    end
  end

  assign o_Count  = count;
  assign o_Wrap   = wrap;
  assign o_Tick   = tick;
  assign o_Busy   = (state == RUN);
  assign o_TwoSec = (state == DONE);

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: wrap and saturate instances share stimulus and are
// checked each cycle against an edge-counting reference model.
module tb_tick_timer;

  localparam int DIV  = 5;
  localparam int T    = 3;
  localparam int TO   = DIV * T;
  localparam int MAXV = 7;

  logic       clk_50M = 1'b0;
  logic       i_Zero, i_Clear, i_Enable, i_TwoSec, i_Abort;
  logic [2:0] c0_count, c1_count;
  logic       c0_wrap, c0_tick, c0_busy, c0_two;
  logic       c1_wrap, c1_tick, c1_busy, c1_two;

  int checks = 0;
  int errors = 0;

  always #5 clk_50M = ~clk_50M;

  tick_timer #(.WIDTH(3), .CLK_HZ(10), .TICK_HZ(2), .TIMEOUT_TICKS(3), .SATURATE(1'b0)) u0 (
    .clk_50M(clk_50M), .i_Zero(i_Zero), .i_Clear(i_Clear), .i_Enable(i_Enable),
    .i_TwoSec(i_TwoSec), .i_Abort(i_Abort), .o_Count(c0_count), .o_Wrap(c0_wrap),
    .o_Tick(c0_tick), .o_Busy(c0_busy), .o_TwoSec(c0_two)
  );

  tick_timer #(.WIDTH(3), .CLK_HZ(10), .TICK_HZ(2), .TIMEOUT_TICKS(3), .SATURATE(1'b1)) u1 (
    .clk_50M(clk_50M), .i_Zero(i_Zero), .i_Clear(i_Clear), .i_Enable(i_Enable),
    .i_TwoSec(i_TwoSec), .i_Abort(i_Abort), .o_Count(c1_count), .o_Wrap(c1_wrap),
    .o_Tick(c1_tick), .o_Busy(c1_busy), .o_TwoSec(c1_two)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: edges since the last prescaler realignment, and edges
  // remaining until expiry, instead of prescaler/tick registers.
  int m_age  = 0;
  bit m_busy = 0;
  bit m_done = 0;
  int m_left = 0;
  int m_cnt[2] = '{0, 0};
  bit m_wrap[2] = '{0, 0};

  task automatic model_step();
    bit load;
    load = 0;
    if (i_Zero) begin
      m_age = 0; m_busy = 0; m_done = 0; m_left = 0;
      for (int s = 0; s < 2; s++) begin m_cnt[s] = 0; m_wrap[s] = 0; end
      return;
    end
    if (i_Abort) begin
      m_busy = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (i_TwoSec) begin
        m_left = TO; load = 1;
      end else begin
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_done = 1; end
      end
    end else if (i_TwoSec) begin
      m_busy = 1; m_left = TO; load = 1;
    end
    m_age = load ? 0 : m_age + 1;
    for (int s = 0; s < 2; s++) begin
      if (i_Clear) begin
        m_cnt[s] = 0; m_wrap[s] = 0;
      end else if (i_Enable) begin
        if (s == 1) begin
          if (m_cnt[s] == MAXV) m_wrap[s] = 0;
          else begin m_cnt[s]++; m_wrap[s] = (m_cnt[s] == MAXV); end
        end else begin
          m_cnt[s] = (m_cnt[s] + 1) % (MAXV + 1);
          m_wrap[s] = (m_cnt[s] == 0);
        end
      end else begin
        m_wrap[s] = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk_50M or posedge i_Zero);
    model_step();
  end

  initial forever begin
    @(negedge clk_50M);
    chk("u0_tick",  32'(c0_tick),  32'(m_age % DIV == DIV - 1));
    chk("u1_tick",  32'(c1_tick),  32'(m_age % DIV == DIV - 1));
    chk("u0_busy",  32'(c0_busy),  32'(m_busy));
    chk("u1_busy",  32'(c1_busy),  32'(m_busy));
    chk("u0_two",   32'(c0_two),   32'(m_done));
    chk("u1_two",   32'(c1_two),   32'(m_done));
    chk("u0_count", 32'(c0_count), 32'(m_cnt[0]));
    chk("u1_count", 32'(c1_count), 32'(m_cnt[1]));
    chk("u0_wrap",  32'(c0_wrap),  32'(m_wrap[0]));
    chk("u1_wrap",  32'(c1_wrap),  32'(m_wrap[1]));
  end

  task automatic edge_();
    @(posedge clk_50M);
    #3;
  endtask

  initial begin
    i_Zero = 1; i_Clear = 0; i_Enable = 0; i_TwoSec = 0; i_Abort = 0;
    repeat (3) edge_();
    chk("rst_count", 32'(c0_count), 0);
    chk("rst_wrap",  32'(c0_wrap),  0);
    chk("rst_tick",  32'(c0_tick),  0);
    chk("rst_busy",  32'(c0_busy),  0);
    chk("rst_two",   32'(c0_two),   0);
    i_Zero = 0;

    // Cycle k+1 is the period following edge k after release.
    for (int k = 1; k <= 20; k++) begin
      edge_();
      chk("freerun_tick", 32'(c0_tick), 32'((k + 1) % 5 == 0));
    end

    i_TwoSec = 1; edge_(); i_TwoSec = 0;
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) edge_();
      chk("to_busy", 32'(c0_busy), 32'(j < 15));
      chk("to_two",  32'(c0_two),  32'(j == 15));
    end

    i_TwoSec = 1; edge_(); i_TwoSec = 0;
    for (int j = 1; j <= 24; j++) begin
      edge_();
      chk("retrig_two", 32'(c0_two), 32'(j == 22));
      i_TwoSec = (j == 6);
    end

    i_TwoSec = 1; edge_(); i_TwoSec = 0;
    for (int j = 1; j <= 20; j++) begin
      edge_();
      chk("abort_busy", 32'(c0_busy), 32'(j < 4));
      chk("abort_two",  32'(c0_two),  0);
      i_Abort = (j == 3);
    end

    i_Clear = 1; edge_(); i_Clear = 0; i_Enable = 1;
    for (int j = 1; j <= 9; j++) begin
      edge_();
      chk("wrap_cnt0", 32'(c0_count), 32'(j % 8));
      chk("wrap_w0",   32'(c0_wrap),  32'(j == 8));
      chk("sat_cnt1",  32'(c1_count), 32'((j > 7) ? 7 : j));
      chk("sat_w1",    32'(c1_wrap),  32'(j == 7));
    end
    i_Enable = 0;

    i_Clear = 1; edge_(); i_Clear = 0; i_Enable = 1;
    repeat (5) edge_();
    chk("clr_pre", 32'(c0_count), 5);
    i_Clear = 1;
    edge_();
    chk("clr_cnt0", 32'(c0_count), 0);
    chk("clr_w0",   32'(c0_wrap),  0);
    chk("clr_cnt1", 32'(c1_count), 0);
    chk("clr_w1",   32'(c1_wrap),  0);
    i_Clear = 0;

    i_TwoSec = 1; edge_(); i_TwoSec = 0;
    repeat (10) edge_();
    i_Enable = 0;
    #4 i_Zero = 1;
    #1;
    chk("mid_busy",  32'(c0_busy),  0);
    chk("mid_two",   32'(c0_two),   0);
    chk("mid_tick",  32'(c0_tick),  0);
    chk("mid_count", 32'(c1_count), 0);
    chk("mid_wrap",  32'(c0_wrap),  0);
    edge_(); edge_();
    i_Zero = 0;
    for (int j = 1; j <= 20; j++) begin
      edge_();
      chk("post_two", 32'(c0_two), 0);
    end

    for (int c = 0; c < 3000; c++) begin
      edge_();
      i_Enable = ($urandom_range(0, 1) == 0);
      i_Clear  = ($urandom_range(0, 9) == 0);
      i_TwoSec = ($urandom_range(0, 29) == 0);
      i_Abort  = ($urandom_range(0, 39) == 0);
      i_Zero   = ($urandom_range(0, 499) == 0);
    end
    i_Zero = 0; i_Enable = 0; i_Clear = 0; i_TwoSec = 0; i_Abort = 0;
    repeat (3) edge_();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
